// File: rtl/fetch_sequencer_pkg.sv
// Shared definitions for the instruction fetch sequencer.
//   PC_W          : default word-address width of the instruction memory
//   INSTR_W       : default instruction width
//   HALT_SENTINEL : instruction word that stops fetching (all ones)
//   fsm_state_t   : fetch FSM state encoding (IDLE, FETCH, HALT)
package fetch_sequencer_pkg;

    localparam int PC_W    = 8;
    localparam int INSTR_W = 32;

    localparam logic [31:0] HALT_SENTINEL = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_HALT  = 2'd2
    } fsm_state_t;

endpackage

// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer with a one-cycle fetch latency.
// Drives pc to a combinational instruction memory owned by the parent and
// registers the returned word into a single output slot.
//
// Ports:
//   clk, reset      : single clock, synchronous active-high reset
//   start, start_pc : one-cycle pulse that begins fetching at start_pc
//                     (honoured only in IDLE and HALT)
//   pc              : address presented to the instruction memory
//   instruction     : memory data for pc, valid in the same cycle
//   branch_taken,
//   branch_target   : redirect in FETCH; flushes the output slot
//   instr_out,
//   pc_out          : registered instruction and its address
//   valid_out       : output slot holds a live instruction
//   ready_in        : downstream accepts the slot this cycle
//   halted          : high while in HALT
//   fetch_count     : saturating count of accepted instructions
//   dbg_state       : current FSM state, for observation only
//
// Handshake: the output slot transfers on every cycle where valid_out and
// ready_in are both high. While valid_out is high and ready_in is low the
// slot and pc hold. A branch flush drops the slot even if it is being
// accepted in that same cycle; that acceptance still counts.
module fetch_sequencer #(
    parameter int PC_W    = fetch_sequencer_pkg::PC_W,
    parameter int INSTR_W = fetch_sequencer_pkg::INSTR_W
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [PC_W-1:0]    start_pc,
    output logic [PC_W-1:0]    pc,
    input  logic [INSTR_W-1:0] instruction,
    input  logic               branch_taken,
    input  logic [PC_W-1:0]    branch_target,
    output logic [INSTR_W-1:0] instr_out,
    output logic [PC_W-1:0]    pc_out,
    output logic               valid_out,
    input  logic               ready_in,
    output logic               halted,
    output logic [15:0]        fetch_count,
    output logic [1:0]         dbg_state
);

    import fetch_sequencer_pkg::*;

    fsm_state_t         r_state;
    logic [PC_W-1:0]    r_pc;
    logic [INSTR_W-1:0] r_instr;
    logic [PC_W-1:0]    r_pc_out;
    logic               r_valid;
    logic               r_halted;
    logic [15:0]        r_count;

    fsm_state_t         w_state_n;
    logic [PC_W-1:0]    w_pc_n;
    logic [INSTR_W-1:0] w_instr_n;
    logic [PC_W-1:0]    w_pc_out_n;
    logic               w_valid_n;
    logic               w_halted_n;
    logic               w_advance;
    logic               w_is_sentinel;
    logic               w_accept;

    // The halt sentinel is the all-ones word at any instruction width.
    assign w_is_sentinel = &instruction;
    assign w_advance     = !r_valid || ready_in;
    assign w_accept      = r_valid && ready_in;

    always_comb begin
        w_state_n  = r_state;
        w_pc_n     = r_pc;
        w_instr_n  = r_instr;
        w_pc_out_n = r_pc_out;
        w_valid_n  = r_valid;
        w_halted_n = r_halted;

        case (r_state)
            S_IDLE, S_HALT: begin
                w_valid_n = 1'b0;
                if (start) begin
                    w_pc_n     = start_pc;
                    w_halted_n = 1'b0;
                    w_state_n  = S_FETCH;
                end
            end

            S_FETCH: begin
                // A redirect outranks stall and sentinel detection: the
                // word at the old pc is discarded, leaving one bubble.
                if (branch_taken) begin
                    w_pc_n    = branch_target;
                    w_valid_n = 1'b0;
                end else if (w_advance) begin
                    if (w_is_sentinel) begin
                        // pc stays on the sentinel address.
                        w_valid_n  = 1'b0;
                        w_halted_n = 1'b1;
                        w_state_n  = S_HALT;
                    end else begin
                        w_instr_n  = instruction;
                        w_pc_out_n = r_pc;
                        w_valid_n  = 1'b1;
                        w_pc_n     = r_pc + PC_W'(1);
                    end
                end
            end

            default: begin
                w_state_n = S_IDLE;
                w_valid_n = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_pc     <= '0;
            r_instr  <= '0;
            r_pc_out <= '0;
            r_valid  <= 1'b0;
            r_halted <= 1'b0;
        end else begin
            r_state  <= w_state_n;
            r_pc     <= w_pc_n;
            r_instr  <= w_instr_n;
            r_pc_out <= w_pc_out_n;
            r_valid  <= w_valid_n;
            r_halted <= w_halted_n;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_count <= '0;
        end else if (w_accept && (r_count != 16'hFFFF)) begin
            r_count <= r_count + 16'd1;
        end
    end

    assign pc          = r_pc;
    assign instr_out   = r_instr;
    assign pc_out      = r_pc_out;
    assign valid_out   = r_valid;
    assign halted      = r_halted;
    assign fetch_count = r_count;
    assign dbg_state   = r_state;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: directed scenarios followed by a randomized run,
// all checked every cycle against a reference model of the fetch rules.
module tb_fetch_sequencer;

    import fetch_sequencer_pkg::*;

    localparam int PW = 8;
    localparam int IW = 32;
    localparam logic [IW-1:0] SENT = 32'hFFFF_FFFF;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [PW-1:0] start_pc;
    logic [PW-1:0] pc;
    logic [IW-1:0] instruction;
    logic          branch_taken;
    logic [PW-1:0] branch_target;
    logic [IW-1:0] instr_out;
    logic [PW-1:0] pc_out;
    logic          valid_out;
    logic          ready_in;
    logic          halted;
    logic [15:0]   fetch_count;
    logic [1:0]    dbg_state;

    logic [IW-1:0] mem [0:255];

    int total = 0;
    int bad   = 0;

    // Reference model state: 0 = idle, 1 = fetching, 2 = halted.
    int            m_mode;
    logic [PW-1:0] m_pc;
    logic [IW-1:0] m_instr;
    logic [PW-1:0] m_pc_out;
    logic          m_valid;
    logic          m_halted;
    int            m_count;

    logic [PW+IW-1:0] got_q [$];
    logic [PW+IW-1:0] exp_q [$];

    always #5 clk = ~clk;

    assign instruction = mem[pc];

    fetch_sequencer #(.PC_W(PW), .INSTR_W(IW)) dut (
        .clk           (clk),
        .reset         (reset),
        .start         (start),
        .start_pc      (start_pc),
        .pc            (pc),
        .instruction   (instruction),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .instr_out     (instr_out),
        .pc_out        (pc_out),
        .valid_out     (valid_out),
        .ready_in      (ready_in),
        .halted        (halted),
        .fetch_count   (fetch_count),
        .dbg_state     (dbg_state)
    );

    task automatic chk(input string tag, input logic [IW-1:0] obs, input logic [IW-1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [1:0] mode_to_state(input int mode);
        case (mode)
            1:       return S_FETCH;
            2:       return S_HALT;
            default: return S_IDLE;
        endcase
    endfunction

    // One clock edge of the fetch rules, applied to the model.
    task automatic model_edge();
        if (reset) begin
            m_mode = 0; m_pc = '0; m_instr = '0; m_pc_out = '0;
            m_valid = 1'b0; m_halted = 1'b0; m_count = 0;
        end else begin
            if (m_valid && ready_in && m_count < 65535) m_count++;
            if (m_mode == 1) begin
                if (branch_taken) begin
                    m_pc    = branch_target;
                    m_valid = 1'b0;
                end else if (!m_valid || ready_in) begin
                    if (mem[m_pc] == SENT) begin
                        m_valid  = 1'b0;
                        m_halted = 1'b1;
                        m_mode   = 2;
                    end else begin
                        m_instr  = mem[m_pc];
                        m_pc_out = m_pc;
                        m_valid  = 1'b1;
                        m_pc     = m_pc + 8'd1;
                    end
                end
            end else if (start) begin
                m_pc     = start_pc;
                m_halted = 1'b0;
                m_mode   = 1;
            end
        end
    endtask

    task automatic cycle();
        if (valid_out === 1'b1 && ready_in === 1'b1 && reset === 1'b0)
            got_q.push_back({pc_out, instr_out});
        model_edge();
        @(posedge clk);
        #1;
        chk("pc",          IW'(pc),          IW'(m_pc));
        chk("valid_out",   IW'(valid_out),   IW'(m_valid));
        chk("halted",      IW'(halted),      IW'(m_halted));
        chk("fetch_count", IW'(fetch_count), IW'(m_count));
        chk("state",       IW'(dbg_state),   IW'(mode_to_state(m_mode)));
        chk("instr_out",   instr_out,        m_instr);
        chk("pc_out",      IW'(pc_out),      IW'(m_pc_out));
    endtask

    initial begin
        int cnt0;

        reset = 1'b1; start = 1'b0; start_pc = '0; branch_taken = 1'b0;
        branch_target = '0; ready_in = 1'b0;
        m_mode = 0; m_pc = '0; m_instr = '0; m_pc_out = '0;
        m_valid = 1'b0; m_halted = 1'b0; m_count = 0;
        for (int i = 0; i < 256; i++) mem[i] = SENT;
        for (int i = 0; i < 7; i++) mem[i] = 32'h1000_0000 + i;

        // Reset state
        cycle(); cycle();
        chk("rst_pc", IW'(pc), 0);
        chk("rst_valid", IW'(valid_out), 0);
        chk("rst_count", IW'(fetch_count), 0);
        chk("rst_state", IW'(dbg_state), IW'(S_IDLE));
        reset = 1'b0;
        cycle();

        // Run words 0..6 to the sentinel
        got_q.delete();
        start = 1'b1; start_pc = 8'd0; ready_in = 1'b1;
        cycle();
        start = 1'b0;
        for (int i = 0; i < 20 && halted !== 1'b1; i++) cycle();
        chk("run_halted", IW'(halted), 1);
        chk("run_pc", IW'(pc), 7);
        chk("run_count", IW'(fetch_count), 7);
        for (int i = 0; i < 7; i++) exp_q.push_back({8'(i), 32'h1000_0000 + 32'(i)});
        chk("run_len", IW'(got_q.size()), 7);
        while (exp_q.size() > 0 && got_q.size() > 0) begin
            logic [PW+IW-1:0] g, e;
            g = got_q.pop_front();
            e = exp_q.pop_front();
            chk("run_word", g[IW-1:0], e[IW-1:0]);
            chk("run_addr", IW'(g[PW+IW-1:IW]), IW'(e[PW+IW-1:IW]));
        end
        exp_q.delete();

        // Stall at pc_out=2
        start = 1'b1; start_pc = 8'd0;
        cycle();
        start = 1'b0;
        cycle(); cycle(); cycle();
        ready_in = 1'b0;
        cnt0 = fetch_count;
        cycle(); cycle(); cycle();
        chk("stall_pc_out", IW'(pc_out), 2);
        chk("stall_pc", IW'(pc), 3);
        chk("stall_instr", instr_out, 32'h1000_0002);
        chk("stall_valid", IW'(valid_out), 1);
        chk("stall_count", IW'(fetch_count), IW'(cnt0));

        // Branch to 6 while pc=5
        ready_in = 1'b1;
        cycle(); cycle();
        chk("br_pre_pc", IW'(pc), 5);
        branch_taken = 1'b1; branch_target = 8'd6;
        cycle();
        branch_taken = 1'b0;
        chk("br_bubble", IW'(valid_out), 0);
        cycle();
        chk("br_valid", IW'(valid_out), 1);
        chk("br_pc_out", IW'(pc_out), 6);
        chk("br_instr", instr_out, 32'h1000_0006);
        for (int i = 0; i < 10 && halted !== 1'b1; i++) cycle();
        chk("br_halted", IW'(halted), 1);

        // Start and branch together in HALT, then start during FETCH
        start = 1'b1; start_pc = 8'd3; branch_taken = 1'b1; branch_target = 8'h55;
        cycle();
        start = 1'b0; branch_taken = 1'b0;
        chk("sb_pc", IW'(pc), 3);
        chk("sb_halted", IW'(halted), 0);
        start = 1'b1; start_pc = 8'h80;
        cycle();
        start = 1'b0;
        chk("sf_pc", IW'(pc), 4);

        // Reset during a stall, then branch ignored in IDLE
        ready_in = 1'b0;
        cycle(); cycle();
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        chk("rs_valid", IW'(valid_out), 0);
        chk("rs_pc_out", IW'(pc_out), 0);
        chk("rs_instr", instr_out, 0);
        chk("rs_state", IW'(dbg_state), IW'(S_IDLE));
        branch_taken = 1'b1; branch_target = 8'd9; ready_in = 1'b1;
        cycle(); cycle();
        branch_taken = 1'b0;
        chk("rs_br_pc", IW'(pc), 0);
        chk("rs_br_state", IW'(dbg_state), IW'(S_IDLE));

        // Wrap from 255 to 0
        mem[255] = 32'hABCD_0255;
        start = 1'b1; start_pc = 8'd255;
        cycle();
        start = 1'b0;
        cycle();
        chk("wr_pc_out", IW'(pc_out), 255);
        chk("wr_instr", instr_out, 32'hABCD_0255);
        chk("wr_pc", IW'(pc), 0);
        cycle();
        chk("wr_pc_out0", IW'(pc_out), 0);

        // Randomized traffic
        for (int i = 0; i < 256; i++)
            mem[i] = ($urandom_range(0, 15) == 0) ? SENT : $urandom();
        for (int n = 0; n < 1500; n++) begin
            reset         = ($urandom_range(0, 199) == 0);
            start         = ($urandom_range(0, 19) == 0);
            start_pc      = PW'($urandom_range(0, 255));
            branch_taken  = ($urandom_range(0, 9) == 0);
            branch_target = PW'($urandom_range(0, 255));
            ready_in      = ($urandom_range(0, 3) != 0);
            cycle();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fetch_sequencer.md
FETCH_SEQUENCER -- requirements
Module: fetch_sequencer

Interface
REQ-001 SHALL have parameter PC_W, default 8, giving the word-address width of the instruction memory.
REQ-002 SHALL have parameter INSTR_W, default 32, giving the instruction width.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port start  input  1  one-cycle pulse that begins fetching at start_pc.
REQ-006 SHALL have port start_pc  input  PC_W  first fetch address.
REQ-007 SHALL have port pc  output  PC_W  address driven to the combinational instruction memory.
REQ-008 SHALL have port instruction  input  INSTR_W  memory read data for pc, valid the same cycle.
REQ-009 SHALL have port branch_taken  input  1  redirect request from decode/execute.
REQ-010 SHALL have port branch_target  input  PC_W  absolute word address for the redirect.
REQ-011 SHALL have port instr_out  output  INSTR_W  registered fetched instruction.
REQ-012 SHALL have port pc_out  output  PC_W  address of instr_out.
REQ-013 SHALL have port valid_out  output  1  instr_out/pc_out hold a live instruction.
REQ-014 SHALL have port ready_in  input  1  downstream accepts instr_out this cycle.
REQ-015 SHALL have port halted  output  1  high while in HALT.
REQ-016 SHALL have port fetch_count  output  16  count of accepted instructions.

Function
REQ-017 SHALL implement a three-state FSM: IDLE, FETCH, HALT.
REQ-018 In IDLE and HALT, start SHALL load pc<=start_pc, clear halted, and enter FETCH next cycle; in FETCH, start SHALL be ignored.
REQ-019 In FETCH, "advance" SHALL be defined as (!valid_out || ready_in).
REQ-020 On advance with no redirect and instruction != HALT_SENTINEL (all ones), the block SHALL register instr_out<=instruction, pc_out<=pc, valid_out<=1, pc<=pc+1 (modulo 2^PC_W; 255 wraps to 0).
REQ-021 On advance with instruction == HALT_SENTINEL, the block SHALL set valid_out<=0, hold pc at the sentinel address, set halted<=1, and enter HALT; the sentinel SHALL never be presented downstream.
REQ-022 When !advance (valid_out && !ready_in), pc, instr_out, pc_out and valid_out SHALL hold unchanged.
REQ-023 branch_taken in FETCH SHALL take priority over advance, stall and sentinel detection: pc<=branch_target and valid_out<=0 (flush), giving exactly one bubble cycle.
REQ-024 branch_taken in IDLE or HALT SHALL be ignored.
REQ-025 fetch_count SHALL increment by 1 on every cycle with valid_out && ready_in (including a flush cycle), saturating at 0xFFFF.
REQ-026 Fetch latency SHALL be one cycle: pc presented in cycle N appears on instr_out with valid_out in cycle N+1.
REQ-027 In IDLE and HALT, valid_out SHALL be 0 and pc SHALL hold.

Reset
REQ-028 reset SHALL take priority over all inputs, including start and branch_taken.
REQ-029 On reset the block SHALL set state=IDLE, pc=0, instr_out=0, pc_out=0, valid_out=0, halted=0, fetch_count=0.
REQ-030 Reset asserted mid-FETCH SHALL discard any held instruction without handshake; the block SHALL then need a start pulse.

Structure
REQ-031 A shared package SHALL hold PC_W, INSTR_W, HALT_SENTINEL (32'hFFFF_FFFF) and the FSM state encoding.
REQ-032 The block SHALL contain no sub-module; the instruction memory SHALL be instantiated by the parent and connected via pc/instruction.

Verification
REQ-033 Bench SHALL run reset, start with start_pc=0, and ready_in=1 on memory words 0..6 followed by sentinels -> instr_out sequence words 0..6 on consecutive cycles, then halted=1, pc=7, fetch_count=7.
REQ-034 Bench SHALL hold ready_in=0 for 3 cycles while valid_out=1 at pc_out=2 -> outputs stable, pc=3 held, no count increment.
REQ-035 Bench SHALL pulse branch_taken with target=6 while pc=5 -> valid_out=0 next cycle, then pc_out=6 with instr word 6.
REQ-036 Bench SHALL start with start_pc=255 on a non-sentinel word -> pc_out=255 then pc wraps to 0.
REQ-037 Bench SHALL assert reset during a stall in FETCH -> all outputs zero, state IDLE, and branch_taken ignored until start.
REQ-038 Bench SHALL assert start and branch_taken together in HALT -> pc=start_pc with the branch ignored; start during FETCH has no effect.
